// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an async input over a fixed gate window.
// Optional FREQ_BCD_EN: edge counter and Freq become packed BCD digits.
module freq_meter #(
  parameter int BoardFreq = 100_000_000,
  parameter int Bits      = 27,
  parameter int CntBits   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Run,
  input  logic               Sig,
  output logic [CntBits-1:0] Freq,
  output logic               Valid,
  output logic               Ovf
);

  localparam logic [Bits-1:0] LP_LAST = Bits'(BoardFreq - 1);

  typedef enum logic {
    S_IDLE,
    S_MEAS
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_edge;
  logic w_term;
  logic w_full;

  logic [Bits-1:0]    r_gate;
  logic [Bits-1:0]    w_gate_nx;
  logic [CntBits-1:0] r_cnt;
  logic [CntBits-1:0] w_cnt_nx;
  logic [CntBits-1:0] w_cnt_inc;
  logic [CntBits-1:0] w_cnt_up;
  logic [CntBits-1:0] r_freq;
  logic [CntBits-1:0] w_freq_nx;

  logic r_sat;
  logic w_sat_nx;
  logic w_sat_up;
  logic r_ovf;
  logic w_ovf_nx;
  logic r_valid;
  logic w_valid_nx;

  assign w_edge = r_s2 & ~r_s3;
  assign w_term = (r_gate == LP_LAST);

`ifdef FREQ_BCD_EN
  localparam int LP_DIG = CntBits / 4;

  logic w_carry;

  // Ripple-carry decimal increment; full means every digit reads 9.
  always_comb begin
    w_carry   = 1'b1;
    w_full    = 1'b1;
    w_cnt_inc = r_cnt;
    for (int i = 0; i < LP_DIG; i++) begin
      if (r_cnt[4*i +: 4] != 4'd9) begin
        w_full = 1'b0;
      end
      if (w_carry) begin
        if (r_cnt[4*i +: 4] == 4'd9) begin
          w_cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end
`else
  assign w_full    = &r_cnt;
  assign w_cnt_inc = r_cnt + CntBits'(1);
`endif

  assign w_cnt_up = (w_edge && !w_full) ? w_cnt_inc : r_cnt;
  assign w_sat_up = r_sat | (w_edge & w_full);

  always_comb begin
    w_state_nx = r_state;
    w_gate_nx  = '0;
    w_cnt_nx   = '0;
    w_sat_nx   = 1'b0;
    w_freq_nx  = r_freq;
    w_ovf_nx   = r_ovf;
    w_valid_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Run) begin
          w_state_nx = S_MEAS;
        end
      end
      S_MEAS: begin
        if (!Run) begin
          w_state_nx = S_IDLE;
        end else if (w_term) begin
          w_freq_nx  = w_cnt_up;
          w_ovf_nx   = w_sat_up;
          w_valid_nx = 1'b1;
        end else begin
          w_gate_nx = r_gate + Bits'(1);
          w_cnt_nx  = w_cnt_up;
          w_sat_nx  = w_sat_up;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_gate  <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_freq  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_s1    <= Sig;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_gate  <= w_gate_nx;
      r_cnt   <= w_cnt_nx;
      r_sat   <= w_sat_nx;
      r_freq  <= w_freq_nx;
      r_ovf   <= w_ovf_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign Freq  = r_freq;
  assign Valid = r_valid;
  assign Ovf   = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table vectors, corner sequences and random Sig against a
// window-sum reference model, on a 16-bit and a 4-bit counter instance.
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int HMAX = 8192;
`ifdef FREQ_BCD_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Run = 1'b0;
  logic        Sig = 1'b0;
  logic [15:0] f0;
  logic [3:0]  f1;
  logic        v0, v1, o0, o1;

  freq_meter #(.BoardFreq(GATE), .Bits(7), .CntBits(16)) u0 (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Sig(Sig),
    .Freq(f0), .Valid(v0), .Ovf(o0)
  );

  freq_meter #(.BoardFreq(GATE), .Bits(7), .CntBits(4)) u1 (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Sig(Sig),
    .Freq(f1), .Valid(v1), .Ovf(o1)
  );

  always #5 Clk = ~Clk;

  int nvec = 0;
  int nerr = 0;

  // Model state: Sig sampled at each edge, last reset edge, window origin.
  bit          hist [HMAX];
  int          ec       = 0;
  int          last_rst = 0;
  bit          active   = 1'b0;
  int          e0       = 0;
  logic [15:0] ef0      = '0;
  logic [3:0]  ef1      = '0;
  logic        eo0      = 1'b0;
  logic        eo1      = 1'b0;
  logic        ev       = 1'b0;

  typedef struct {
    int          per;
    logic [15:0] f0;
    logic [3:0]  f1;
    logic        o1;
  } vec_t;

  vec_t tbl [6];

  function automatic bit smp(int e);
    return (e <= last_rst) ? 1'b0 : hist[e];
  endfunction

  function automatic int win_count(int e);
    int n = 0;
    for (int k = e - GATE + 1; k <= e; k++)
      n += int'(smp(k - 2) & ~smp(k - 3));
    return n;
  endfunction

  function automatic int maxv(int nd);
    return BCD ? (10 ** nd) - 1 : (1 << (4 * nd)) - 1;
  endfunction

  function automatic logic [15:0] enc(int n, int nd);
    int          v;
    logic [15:0] r;
    v = (n > maxv(nd)) ? maxv(nd) : n;
    r = '0;
    if (BCD) begin
      for (int d = 0; d < nd; d++) begin
        r[4*d +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end else begin
      r = 16'(v);
    end
    return r;
  endfunction

  function automatic bit pat(int per, int e);
    if (per == 0) return 1'b0;
    if (per < 0) return 1'b1;
    return (e % per) < (per / 2);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0h want %0h", name, ec, act, exp);
    end
  endtask

  task automatic step(bit rst, bit run, bit sig);
    int          n;
    logic [15:0] t;
    Rst = rst;
    Run = run;
    Sig = sig;
    @(posedge Clk);
    ec++;
    if (ec >= HMAX) begin
      $display("FAIL history bound at edge %0d", ec);
      $fatal(1);
    end
    hist[ec] = sig;
    ev = 1'b0;
    if (rst) begin
      last_rst = ec;
      active   = 1'b0;
      ef0      = '0;
      ef1      = '0;
      eo0      = 1'b0;
      eo1      = 1'b0;
    end else if (!run) begin
      active = 1'b0;
    end else if (!active) begin
      active = 1'b1;
      e0     = ec;
    end else if ((ec - e0) % GATE == 0) begin
      n   = win_count(ec);
      ev  = 1'b1;
      ef0 = enc(n, 4);
      t   = enc(n, 1);
      ef1 = t[3:0];
      eo0 = n > maxv(4);
      eo1 = n > maxv(1);
    end
    #1;
    chk("valid0", v0, ev);
    chk("valid1", v1, ev);
    chk("freq0", f0, ef0);
    chk("freq1", f1, ef1);
    chk("ovf0", o0, eo0);
    chk("ovf1", o1, eo1);
  endtask

  task automatic run_n(int n, bit rst, bit run, int per);
    for (int i = 0; i < n; i++) step(rst, run, pat(per, ec + 1));
  endtask

  initial begin
    int thr;
    if (BCD) begin
      tbl[0] = '{10, 16'h0010, 4'd9, 1'b1};
      tbl[1] = '{0, 16'h0000, 4'd0, 1'b0};
      tbl[2] = '{2, 16'h0050, 4'd9, 1'b1};
      tbl[3] = '{20, 16'h0005, 4'd5, 1'b0};
      tbl[4] = '{4, 16'h0025, 4'd9, 1'b1};
      tbl[5] = '{5, 16'h0020, 4'd9, 1'b1};
    end else begin
      tbl[0] = '{10, 16'd10, 4'd10, 1'b0};
      tbl[1] = '{0, 16'd0, 4'd0, 1'b0};
      tbl[2] = '{2, 16'd50, 4'd15, 1'b1};
      tbl[3] = '{20, 16'd5, 4'd5, 1'b0};
      tbl[4] = '{4, 16'd25, 4'd15, 1'b1};
      tbl[5] = '{5, 16'd20, 4'd15, 1'b1};
    end

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_freq", f0, 16'd0);
    chk("rst_valid", v0, 16'd0);
    step(1'b0, 1'b1, 1'b0);

    // Back-to-back windows; the third window of each entry is clean.
    for (int i = 0; i < 6; i++) begin
      run_n(3 * GATE, 1'b0, 1'b1, tbl[i].per);
      chk("tbl_valid", v0, 16'd1);
      chk("tbl_f0", f0, tbl[i].f0);
      chk("tbl_f1", f1, 16'(tbl[i].f1));
      chk("tbl_o1", o1, 16'(tbl[i].o1));
    end

    // Run low while gate is 60, then restart.
    run_n(60, 1'b0, 1'b1, 10);
    run_n(30, 1'b0, 1'b0, 10);
    chk("hold_f0", f0, tbl[5].f0);
    run_n(100, 1'b0, 1'b1, 10);
    chk("rerun_early", v0, 16'd0);
    run_n(1, 1'b0, 1'b1, 10);
    chk("rerun_valid", v0, 16'd1);
    chk("rerun_f0", f0, BCD ? 16'h0010 : 16'd10);

    // Run low exactly on the terminal cycle suppresses Valid.
    run_n(GATE - 1, 1'b0, 1'b1, 10);
    run_n(1, 1'b0, 1'b0, 10);
    chk("term_drop", v0, 16'd0);
    run_n(5, 1'b0, 1'b0, 10);

    // Saturating window, then reset mid-window.
    run_n(GATE + 1, 1'b0, 1'b1, 2);
    chk("sat_o1", o1, 16'd1);
    run_n(40, 1'b0, 1'b1, 2);
    run_n(1, 1'b1, 1'b1, -1);
    chk("mid_rst_f0", f0, 16'd0);
    chk("mid_rst_o1", o1, 16'd0);
    chk("mid_rst_v", v0, 16'd0);

    // Sig held high through reset release counts as one edge.
    run_n(GATE + 1, 1'b0, 1'b1, -1);
    chk("held_valid", v0, 16'd1);
    chk("held_f0", f0, 16'd1);

    // Random density per window.
    for (int w = 0; w < 6; w++) begin
      thr = $urandom_range(0, 9);
      for (int k = 0; k < GATE; k++)
        step(1'b0, 1'b1, $urandom_range(0, 9) < thr);
    end
    run_n(37, 1'b0, 1'b0, 0);
    for (int k = 0; k < 2 * GATE + 3; k++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
